// File: rtl/linear_network_gather_seq_pkg.sv
// ============================================================================
// Module   : linear_network_gather_seq_pkg
// Brief    : Shared types and helpers for the sequential gather network.
// Revision : 1.0
// ============================================================================
`default_nettype none

package linear_network_gather_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Node index width, kept at least one bit so a single-node chain still has a port.
   function automatic int node_id_width(input int num_node);
      return (num_node > 1) ? $clog2(num_node) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/linear_network_gather_seq_lowest_set_bit_finder.sv
// ============================================================================
// Module   : lowest_set_bit_finder
// Brief    : Combinational priority pick of the lowest set bit of a mask.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lowest_set_bit_finder #(
   parameter int NUM_NODE  = 4,
   parameter int IDX_WIDTH = 2
) (
   input  logic [NUM_NODE-1:0]  mask,
   output logic [IDX_WIDTH-1:0] idx,
   output logic [NUM_NODE-1:0]  onehot,
   output logic                 any_set
);

   assign any_set = |mask;
   assign onehot  = mask & (~mask + NUM_NODE'(1));

   always_comb begin
      idx = '0;
      for (int k = NUM_NODE - 1; k >= 0; k--) begin
         if (mask[k]) begin
            idx = IDX_WIDTH'(k);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/linear_network_gather_seq.sv
// ============================================================================
// Module   : linear_network_gather_seq
// Brief    : Drains one word from each selected node, ascending order, onto one stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module linear_network_gather_seq
   import linear_network_gather_seq_pkg::*;
#(
   parameter  int DATA_WIDTH    = 32,
   parameter  int NUM_NODE      = 4,
   localparam int NODE_ID_WIDTH = node_id_width(NUM_NODE)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_en,
   input  logic                           i_cmd_valid,
   input  logic [NUM_NODE-1:0]            i_cmd,
   output logic                           o_cmd_ready,
   input  logic [NUM_NODE-1:0]            i_valid,
   input  logic [DATA_WIDTH*NUM_NODE-1:0] i_data_bus,
   output logic [NUM_NODE-1:0]            o_ready,
   output logic                           o_valid,
   output logic [DATA_WIDTH-1:0]          o_data_bus,
   output logic [NODE_ID_WIDTH-1:0]       o_node_id,
   input  logic                           i_ready,
   output logic                           o_done
);

   state_t                   state;
   state_t                   state_nxt;
   logic [NUM_NODE-1:0]      mask;
   logic [NUM_NODE-1:0]      mask_nxt;
   logic [NUM_NODE-1:0]      ptr_onehot;
   logic [NODE_ID_WIDTH-1:0] ptr;
   logic                     any_set;
   logic                     slot_free;
   logic                     scan_go;
   logic                     node_fire;
   logic                     done_nxt;

   lowest_set_bit_finder #(
      .NUM_NODE  (NUM_NODE),
      .IDX_WIDTH (NODE_ID_WIDTH)
   ) u_ptr (
      .mask    (mask),
      .idx     (ptr),
      .onehot  (ptr_onehot),
      .any_set (any_set)
   );

   assign slot_free   = !o_valid || i_ready;
   assign scan_go     = i_en && (state == SCAN) && slot_free && any_set;
   assign o_ready     = scan_go ? ptr_onehot : '0;
   assign node_fire   = scan_go && |(i_valid & ptr_onehot);
   assign o_cmd_ready = rst_n && i_en && (state == IDLE);

   always_comb begin
      state_nxt = state;
      mask_nxt  = mask;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (i_cmd_valid && o_cmd_ready) begin
               if (|i_cmd) begin
                  mask_nxt  = i_cmd;
                  state_nxt = SCAN;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end
         SCAN: begin
            if (node_fire) begin
               mask_nxt = mask & ~ptr_onehot;
               if (mask_nxt == '0) begin
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            // An empty slot also completes, so a word drained while frozen cannot strand us here.
            if (i_en && slot_free) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mask   <= '0;
         o_done <= 1'b0;
      end else begin
         state  <= state_nxt;
         mask   <= mask_nxt;
         o_done <= done_nxt;
      end
   end

   // Single-entry output slot; downstream may drain it even while the block is frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid    <= 1'b0;
         o_data_bus <= '0;
         o_node_id  <= '0;
      end else if (node_fire) begin
         o_valid    <= 1'b1;
         o_data_bus <= i_data_bus[ptr*DATA_WIDTH +: DATA_WIDTH];
         o_node_id  <= ptr;
      end else if (i_ready) begin
         o_valid    <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: doc/linear_network_gather_seq.md
Name: linear_network_gather_seq

Overview:
Sequential gather (collect) network, the reverse direction of the linear one-hot multicast distributor. A NUM_NODE-bit selection mask picks which nodes are collected. The block drains one data word from each selected node, in ascending node order, onto a single output stream with a valid/ready handshake. It sits between a row of PEs/nodes and a single upstream buffer or writeback port.

Parameters:
DATA_WIDTH, 32, width of one node's data word (arbitrary ≥1)
NUM_NODE, 4, number of nodes on the chain (arbitrary ≥1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
i_en  input  1  block enable; low = freeze
i_cmd_valid  input  1  selection command valid
i_cmd  input  NUM_NODE  selection mask; bit k = collect node k
o_cmd_ready  output  1  command accepted when high with i_cmd_valid
i_valid  input  NUM_NODE  per-node data valid
i_data_bus  input  DATA_WIDTH*NUM_NODE  node k data at [k*DATA_WIDTH+:DATA_WIDTH]
o_ready  output  NUM_NODE  per-node ready; node k word consumed when i_valid[k]&&o_ready[k]
o_valid  output  1  gathered word valid
o_data_bus  output  DATA_WIDTH  gathered word
o_node_id  output  NODE_ID_WIDTH  source node index of o_data_bus
i_ready  input  1  downstream ready
o_done  output  1  one-cycle pulse: command fully drained

Behaviour:
- Reset (async, rst_n=0): state=IDLE, mask register=0, o_valid=0, o_data_bus=0, o_node_id=0, o_done=0. Combinational outputs evaluate to o_cmd_ready=0 and o_ready=0 (i_en is don't-care during reset).
- States: IDLE, SCAN, DRAIN.
- IDLE: o_cmd_ready = i_en.
  - Command handshake with nonzero mask -> latch mask, go to SCAN.
  - Command handshake with zero mask -> o_done=1 next cycle, stay IDLE.
- SCAN: o_cmd_ready=0. ptr = index of the lowest set bit of the remaining mask.
  - slot_free = !o_valid || i_ready.
  - o_ready[k] = i_en && state==SCAN && k==ptr && slot_free. All other bits are 0; unselected nodes never see ready.
  - Node handshake: on the next edge, o_data_bus <= node ptr data, o_node_id <= ptr, o_valid <= 1, and bit ptr is cleared from the mask.
  - If the cleared bit was the last one, go to DRAIN.
  - If i_valid[ptr]=0, stall on ptr; never skip to a later node. Strict ascending order.
  - If the slot is freed and there is no new capture, o_valid <= 0.
- Output register: a single entry. While o_valid && !i_ready, o_data_bus and o_node_id hold stable. Throughput is 1 word/cycle under continuous valid/ready. Latency is 1 cycle from node handshake to o_valid.
- DRAIN: wait for o_valid && i_ready. On that edge o_valid <= 0, o_done <= 1 for one cycle, state -> IDLE.
- o_done is registered and always a single-cycle pulse.
- i_en=0: o_ready=0, o_cmd_ready=0, no state/mask change, no capture. The output register keeps o_valid/o_data_bus, and a downstream handshake on the held word still completes. Exception: in DRAIN, completion (o_done, return to IDLE) waits for i_en=1.
- Reset mid-operation: pending mask discarded; any held output word is dropped (o_valid=0).
- NODE_ID_WIDTH = max(1, $clog2(NUM_NODE)). NUM_NODE=1: o_node_id is always 0.

Decomposition:
- Shared package/header: NODE_ID_WIDTH function/constant, state encoding (IDLE=2'd0, SCAN=2'd1, DRAIN=2'd2).
- One sub-module: lowest_set_bit_finder (NUM_NODE-bit mask in -> index and one-hot out, plus any_set flag). Purely combinational; reused for ptr generation.

Test Plan:
- Basic gather: i_cmd=4'b1011, all i_valid=1, node k data=0xA0+k, i_ready=1 -> o_data_bus 0xA0,0xA1,0xA3 on consecutive cycles with o_node_id 0,1,3; o_ready[2] never high; o_done pulses the cycle after 0xA3's handshake.
- Backpressure: same command with i_ready=0 for 3 cycles while o_data_bus=0xA1 -> 0xA1/id 1 held stable, o_ready all 0 during the stall, sequence resumes with 0xA3 unchanged.
- Late node: mask 4'b0110, i_valid[1] rises 5 cycles after command -> no output and o_ready[1]=1 throughout; node 2 is not collected first; outputs ids 1 then 2.
- Zero mask: i_cmd=0 accepted -> o_done one cycle later, o_valid never asserted, state remains IDLE.
- Enable freeze and reset: i_en=0 for 4 cycles mid-SCAN -> o_ready=0, mask unchanged, held word still drains; then rst_n=0 mid-SCAN -> o_valid=0, o_done=0, o_cmd_ready high after reset release with i_en=1.
- Command exclusion: second i_cmd_valid during SCAN/DRAIN -> o_cmd_ready=0, not accepted until IDLE; back-to-back commands 4'b0001 then 4'b1000 yield ids 0 then 3 with two o_done pulses.
